lcd_dbi_writer: RTL and testbench
=================================

Name: lcd_dbi_writer

Overview:
- Parametrised MIPI-DBI Type-B (8080-style) write engine; successor to the fixed 8-bit write path inside the ILI934x driver.
- Accepts one transaction at a time: command byte, data byte, streamed pixels, or hardware solid fill.
- Generates cs_n/dc/wr_n/data bus timing with programmable pulse and recovery lengths, for an 8- or 16-bit panel bus.
- Sits between the panel init/window sequencer and the pixel source.

Parameters:
- BUS_W, 8: panel data bus width. Legal values are 8 or 16; any other value triggers an elaboration $fatal.
- WR_PULSE_CYC, 2: clk cycles wr_n is held low per beat. Must be ≥1.
- WR_RECOV_CYC, 1: clk cycles wr_n is held high after each beat, data held stable. Must be ≥1.
- CNT_W, 17: width of the pixel count (76800 = 240×320 fits).

Ports:
- clk  in  1  single clock for all logic
- rst  in  1  reset, asynchronous, active-high
- txn_valid  in  1  transaction request
- txn_ready  out  1  high only in IDLE
- txn_kind  in  2  0=CMD, 1=DAT, 2=STREAM, 3=FILL
- txn_data  in  16  CMD/DAT: byte in [7:0]; FILL: RGB565 colour
- txn_count  in  CNT_W  STREAM/FILL pixel count; ignored for CMD/DAT
- pix_data  in  16  RGB565 pixel
- pix_valid  in  1  pixel available
- pix_ready  out  1  high only in FETCH
- busy  out  1  high whenever state≠IDLE
- done  out  1  one-cycle pulse when a transaction completes
- lcd_cs_n  out  1  chip select, low while state≠IDLE
- lcd_dc  out  1  0=command, 1=data
- lcd_wr_n  out  1  write strobe; the panel latches on the rising edge
- lcd_d  out  BUS_W  panel data bus

Behaviour:
- Reset (async, immediate): state=IDLE; outputs are cs_n=1, wr_n=1, dc=1, lcd_d=0, busy=0, done=0, pix_ready=0, txn_ready=1. Reset mid-beat aborts the beat with no completion and no done pulse.
- FSM states: IDLE, FETCH, WR_LO, WR_HI, DONE.
- IDLE:
  - Accept on txn_valid&&txn_ready; latch kind, data and count.
  - CMD/DAT → WR_LO.
  - STREAM → FETCH.
  - FILL → WR_LO, using txn_data as the pixel.
  - STREAM/FILL with count=0 → DONE (no beats, cs_n low for exactly 1 cycle).
- FETCH: pix_ready=1. On pix_valid, latch pix_data → WR_LO. Otherwise stay; wr_n stays 1, cs_n stays 0.
- WR_LO: wr_n=0 for WR_PULSE_CYC cycles, then → WR_HI. dc and lcd_d are stable throughout WR_LO and WR_HI.
- WR_HI: wr_n=1 for WR_RECOV_CYC cycles. Then:
  - more beats in the current pixel → WR_LO;
  - else remaining pixels>0 → FETCH (STREAM) or WR_LO (FILL);
  - else → DONE.
- DONE: done=1 for one cycle → IDLE. A new txn_valid is accepted on the following cycle.
- Beats per item:
  - CMD/DAT: 1 beat. lcd_d = byte, zero-extended when BUS_W=16. dc=0 for CMD, 1 for DAT.
  - Pixel, BUS_W=16: 1 beat, full 16-bit value.
  - Pixel, BUS_W=8: 2 beats, [15:8] then [7:0].
- Timing (P=WR_PULSE_CYC, R=WR_RECOV_CYC), with accept at cycle 0:
  - CMD: wr_n low cycles 1..P, high P+1..P+R; done at cycle P+R+1.
  - Pixel cost: STREAM adds 1 FETCH cycle per pixel at minimum; FILL has no FETCH overhead.
- Counters:
  - Remaining-pixel counter is CNT_W bits and decrements after the last beat of each pixel; it never wraps (terminal at 0).
  - Beat-phase timer is sized $clog2(max(P,R)+1).
- txn_valid outside IDLE is ignored; the next request is held off by txn_ready=0.
- lcd_rd_n and lcd_rst_n are not owned by this block.

Decomposition:
- Package lcd_dbi_pkg contains: txn_kind_e enum (TXN_CMD, TXN_DAT, TXN_STREAM, TXN_FILL), state_e enum, RGB565 pixel typedef.
- Sub-module lcd_dbi_beat: the WR_LO/WR_HI phase timer. It takes start and produces wr_n plus a beat_end pulse.

Test Plan:
- Default parameters, rst held then released: cs_n=1, wr_n=1, dc=1, lcd_d=0, txn_ready=1, busy=0 both during reset and after release.
- CMD 0x2C, BUS_W=8, P=2, R=1:
  - dc=0, lcd_d=0x2C, wr_n low 2 cycles then high 1;
  - done at cycle 4 after accept;
  - exactly one wr_n rising edge.
- STREAM count=2, pixels 0xF800, 0x07E0, BUS_W=8: bytes on wr_n rising edges are F8,00,07,E0, all with dc=1; exactly 2 pix handshakes; single done.
- FILL count=3, txn_data=0x001F, BUS_W=16: three beats of 0x001F; pix_ready never asserted; done 10 cycles after accept (3×3 + 1).
- STREAM, pix_valid dropped for 5 cycles between pixels: wr_n held 1 and cs_n held 0 for those 5 cycles; byte order unchanged; FILL/STREAM with count=0 yields done with zero wr_n edges.
- rst asserted during the 2nd beat of FILL count=100: all outputs return to reset values asynchronously with no done pulse; a following CMD 0x29 completes normally.

Source files
------------

// File: rtl/lcd_dbi_pkg.sv
// rtl/lcd_dbi_pkg.sv - shared types for the DBI Type-B write engine
package lcd_dbi_pkg;

  typedef enum logic [1:0] {
    TXN_CMD    = 2'd0,
    TXN_DAT    = 2'd1,
    TXN_STREAM = 2'd2,
    TXN_FILL   = 2'd3
  } txn_kind_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WR_LO,
    S_WR_HI,
    S_DONE
  } state_e;

  typedef logic [15:0] rgb565_t;

  function automatic logic is_pixel_kind(input txn_kind_e k);
    return (k == TXN_STREAM) || (k == TXN_FILL);
  endfunction

endpackage

// File: rtl/lcd_dbi_beat.sv
// rtl/lcd_dbi_beat.sv - wr_n low/high phase timer for one bus beat
module lcd_dbi_beat #(
  parameter int WR_PULSE_CYC = 2,
  parameter int WR_RECOV_CYC = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic wr_n,
  output logic lo_end,
  output logic beat_end
);

  localparam int MAX_CYC = (WR_PULSE_CYC > WR_RECOV_CYC) ? WR_PULSE_CYC : WR_RECOV_CYC;
  localparam int TW      = $clog2(MAX_CYC + 1);
  localparam logic [TW-1:0] LO_LOAD = TW'(WR_PULSE_CYC - 1);
  localparam logic [TW-1:0] HI_LOAD = TW'(WR_RECOV_CYC - 1);

  logic          lo_q;
  logic          hi_q;
  logic [TW-1:0] cnt_q;

  // start wins over a finishing high phase so back-to-back beats need no gap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lo_q  <= 1'b0;
      hi_q  <= 1'b0;
      cnt_q <= '0;
    end else if (start) begin
      lo_q  <= 1'b1;
      hi_q  <= 1'b0;
      cnt_q <= LO_LOAD;
    end else if (lo_q) begin
      if (cnt_q == '0) begin
        lo_q  <= 1'b0;
        hi_q  <= 1'b1;
        cnt_q <= HI_LOAD;
      end else begin
        cnt_q <= cnt_q - TW'(1);
      end
    end else if (hi_q) begin
      if (cnt_q == '0) begin
        hi_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q - TW'(1);
      end
    end
  end

  assign wr_n     = ~lo_q;
  assign lo_end   = lo_q && (cnt_q == '0);
  assign beat_end = hi_q && (cnt_q == '0);

endmodule

// File: rtl/lcd_dbi_writer.sv
// rtl/lcd_dbi_writer.sv - 8080-style panel write engine for command, data, stream and fill
module lcd_dbi_writer
  import lcd_dbi_pkg::*;
#(
  parameter int BUS_W        = 8,
  parameter int WR_PULSE_CYC = 2,
  parameter int WR_RECOV_CYC = 1,
  parameter int CNT_W        = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             txn_valid,
  output logic             txn_ready,
  input  logic [1:0]       txn_kind,
  input  logic [15:0]      txn_data,
  input  logic [CNT_W-1:0] txn_count,
  input  logic [15:0]      pix_data,
  input  logic             pix_valid,
  output logic             pix_ready,
  output logic             busy,
  output logic             done,
  output logic             lcd_cs_n,
  output logic             lcd_dc,
  output logic             lcd_wr_n,
  output logic [BUS_W-1:0] lcd_d
);

  if (BUS_W != 8 && BUS_W != 16) begin : g_bad_bus_w
    $fatal(1, "lcd_dbi_writer: BUS_W must be 8 or 16");
  end
  if (WR_PULSE_CYC < 1 || WR_RECOV_CYC < 1) begin : g_bad_timing
    $fatal(1, "lcd_dbi_writer: WR_PULSE_CYC and WR_RECOV_CYC must be >= 1");
  end

  state_e           state_q, state_d;
  txn_kind_e        kind_q;
  txn_kind_e        req_kind;
  rgb565_t          pix_q;
  logic [CNT_W-1:0] rem_q;
  logic [CNT_W-1:0] rem_dec;
  logic             low_byte_q;
  logic             more_beats;
  logic [BUS_W-1:0] d_q;
  logic             dc_q;
  logic             beat_start;
  logic             wr_lo_end;
  logic             beat_end;

  // on a narrow bus the high byte goes first; on a wide bus this is the whole pixel
  function automatic logic [BUS_W-1:0] first_beat(input rgb565_t p);
    return p[15 -: BUS_W];
  endfunction

  assign req_kind   = txn_kind_e'(txn_kind);
  assign more_beats = is_pixel_kind(kind_q) && (BUS_W == 8) && !low_byte_q;
  assign rem_dec    = (rem_q == '0) ? '0 : rem_q - CNT_W'(1);

  lcd_dbi_beat #(
    .WR_PULSE_CYC(WR_PULSE_CYC),
    .WR_RECOV_CYC(WR_RECOV_CYC)
  ) u_beat (
    .clk     (clk),
    .rst     (rst),
    .start   (beat_start),
    .wr_n    (lcd_wr_n),
    .lo_end  (wr_lo_end),
    .beat_end(beat_end)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    beat_start = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (txn_valid) begin
          if (is_pixel_kind(req_kind) && txn_count == '0) begin
            state_d = S_DONE;
          end else if (req_kind == TXN_STREAM) begin
            state_d = S_FETCH;
          end else begin
            state_d    = S_WR_LO;
            beat_start = 1'b1;
          end
        end
      end
      S_FETCH: begin
        if (pix_valid) begin
          state_d    = S_WR_LO;
          beat_start = 1'b1;
        end
      end
      S_WR_LO: begin
        if (wr_lo_end) state_d = S_WR_HI;
      end
      S_WR_HI: begin
        if (beat_end) begin
          if (more_beats) begin
            state_d    = S_WR_LO;
            beat_start = 1'b1;
          end else if (rem_dec != '0) begin
            if (kind_q == TXN_STREAM) begin
              state_d = S_FETCH;
            end else begin
              state_d    = S_WR_LO;
              beat_start = 1'b1;
            end
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // CMD/DAT load a zero count so the end-of-beat path falls straight to DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kind_q     <= TXN_CMD;
      pix_q      <= '0;
      rem_q      <= '0;
      low_byte_q <= 1'b0;
      d_q        <= '0;
      dc_q       <= 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (txn_valid) begin
            kind_q     <= req_kind;
            pix_q      <= txn_data;
            low_byte_q <= 1'b0;
            rem_q      <= is_pixel_kind(req_kind) ? txn_count : '0;
            dc_q       <= (req_kind != TXN_CMD);
            if (!is_pixel_kind(req_kind)) d_q <= BUS_W'(txn_data[7:0]);
            else if (req_kind == TXN_FILL) d_q <= first_beat(txn_data);
          end
        end
        S_FETCH: begin
          if (pix_valid) begin
            pix_q      <= pix_data;
            d_q        <= first_beat(pix_data);
            low_byte_q <= 1'b0;
          end
        end
        S_WR_HI: begin
          if (beat_end) begin
            if (more_beats) begin
              low_byte_q <= 1'b1;
              d_q        <= pix_q[BUS_W-1:0];
            end else begin
              rem_q      <= rem_dec;
              low_byte_q <= 1'b0;
              if (kind_q == TXN_FILL) d_q <= first_beat(pix_q);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign txn_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign pix_ready = (state_q == S_FETCH);
  assign done      = (state_q == S_DONE);
  assign lcd_cs_n  = (state_q == S_IDLE);
  assign lcd_dc    = dc_q;
  assign lcd_d     = d_q;

endmodule

// File: tb/tb_lcd_dbi_writer.sv
// tb/tb_lcd_dbi_writer.sv - randomized self-checking bench for lcd_dbi_writer (8- and 16-bit buses)
module tb_lcd_dbi_writer;

  localparam int P = 2;
  localparam int R = 1;
  localparam int K_CMD = 0, K_DAT = 1, K_STREAM = 2, K_FILL = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel16 = 1'b0;
  logic        txn_valid = 1'b0;
  logic [1:0]  txn_kind = 2'd0;
  logic [15:0] txn_data = 16'h0;
  logic [16:0] txn_count = 17'h0;
  logic [15:0] pix_data = 16'h0;
  logic        pix_valid = 1'b0;

  logic        tv8, tv16, pv8, pv16;
  logic        r8, pr8, b8, dn8, cs8, dc8, wr8;
  logic        r16, pr16, b16, dn16, cs16, dc16, wr16;
  logic [7:0]  lcd8;
  logic [15:0] lcd16;
  logic        m_ready, m_pix_ready, m_busy, m_done, m_cs_n, m_dc, m_wr_n;
  logic [15:0] m_d;

  always #5 clk = ~clk;

  assign tv8  = txn_valid & ~sel16;
  assign tv16 = txn_valid & sel16;
  assign pv8  = pix_valid & ~sel16;
  assign pv16 = pix_valid & sel16;

  assign m_ready     = sel16 ? r16  : r8;
  assign m_pix_ready = sel16 ? pr16 : pr8;
  assign m_busy      = sel16 ? b16  : b8;
  assign m_done      = sel16 ? dn16 : dn8;
  assign m_cs_n      = sel16 ? cs16 : cs8;
  assign m_dc        = sel16 ? dc16 : dc8;
  assign m_wr_n      = sel16 ? wr16 : wr8;
  assign m_d         = sel16 ? lcd16 : {8'h00, lcd8};

  lcd_dbi_writer #(.BUS_W(8), .WR_PULSE_CYC(P), .WR_RECOV_CYC(R), .CNT_W(17)) u_dut8 (
    .clk(clk), .rst(rst), .txn_valid(tv8), .txn_ready(r8), .txn_kind(txn_kind),
    .txn_data(txn_data), .txn_count(txn_count), .pix_data(pix_data), .pix_valid(pv8),
    .pix_ready(pr8), .busy(b8), .done(dn8), .lcd_cs_n(cs8), .lcd_dc(dc8),
    .lcd_wr_n(wr8), .lcd_d(lcd8)
  );

  lcd_dbi_writer #(.BUS_W(16), .WR_PULSE_CYC(P), .WR_RECOV_CYC(R), .CNT_W(17)) u_dut16 (
    .clk(clk), .rst(rst), .txn_valid(tv16), .txn_ready(r16), .txn_kind(txn_kind),
    .txn_data(txn_data), .txn_count(txn_count), .pix_data(pix_data), .pix_valid(pv16),
    .pix_ready(pr16), .busy(b16), .done(dn16), .lcd_cs_n(cs16), .lcd_dc(dc16),
    .lcd_wr_n(wr16), .lcd_d(lcd16)
  );

  int checks = 0;
  int failures = 0;

  logic [15:0] src[$];
  logic [16:0] obs_q[$];
  logic [16:0] exp_q[$];
  int   lat, n_hs, n_done, n_cs_low, stall_seen, stall_bad;
  logic pr_seen;
  logic [31:0] wr_trace;

  // Expected bus writes as {dc, data}: what the panel should latch, in order
  task automatic model_beats(input logic s16, input int kind, input logic [15:0] data, input int count);
    exp_q.delete();
    if (kind == K_CMD || kind == K_DAT) begin
      exp_q.push_back({(kind == K_DAT) ? 1'b1 : 1'b0, 8'h00, data[7:0]});
    end else begin
      for (int i = 0; i < count; i++) begin
        logic [15:0] p;
        p = (kind == K_FILL) ? data : src[i];
        if (s16) begin
          exp_q.push_back({1'b1, p});
        end else begin
          exp_q.push_back({1'b1, 8'h00, p[15:8]});
          exp_q.push_back({1'b1, 8'h00, p[7:0]});
        end
      end
    end
  endtask

  function automatic int exp_latency(input logic s16, input int kind, input int count, input int stall);
    int beat_cyc;
    beat_cyc = (s16 ? 1 : 2) * (P + R);
    if (kind == K_CMD || kind == K_DAT) return P + R + 1;
    if (count == 0) return 1;
    if (kind == K_FILL) return count * beat_cyc + 1;
    return count * (1 + beat_cyc) + 1 + stall;
  endfunction

  task automatic run_txn(input logic s16, input int kind, input logic [15:0] data,
                         input int count, input int stall_idx);
    int pi, acc, done_c, stall_left, after;
    logic accepted, hs, prev_wr, saw_done;
    obs_q.delete();
    n_hs = 0; n_done = 0; n_cs_low = 0; stall_seen = 0; stall_bad = 0;
    pr_seen = 1'b0; wr_trace = '1;
    pi = 0; acc = 0; done_c = 0; stall_left = 5; after = 0;
    accepted = 1'b0; prev_wr = 1'b1; saw_done = 1'b0;
    @(posedge clk); #1;
    sel16 = s16;
    txn_kind = kind[1:0]; txn_data = data; txn_count = 17'(count); txn_valid = 1'b1;
    pix_valid = (kind == K_STREAM) && (pi < count) && !(pi == stall_idx && stall_left > 0);
    pix_data = (pi < src.size()) ? src[pi] : 16'h0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (!accepted && txn_valid && m_ready) begin accepted = 1'b1; acc = c; end
      hs = pix_valid && m_pix_ready;
      if (hs) n_hs++;
      if (m_pix_ready) pr_seen = 1'b1;
      if (pi == stall_idx && stall_left > 0 && m_pix_ready && !pix_valid) begin
        stall_seen++;
        if (m_wr_n !== 1'b1 || m_cs_n !== 1'b0) stall_bad++;
        stall_left--;
      end
      if (accepted && (c - acc) < 32) wr_trace[c - acc] = m_wr_n;
      if (accepted && c > acc && m_cs_n === 1'b0) n_cs_low++;
      if (prev_wr === 1'b0 && m_wr_n === 1'b1) obs_q.push_back({m_dc, m_d});
      prev_wr = m_wr_n;
      if (m_done === 1'b1) begin
        n_done++;
        if (!saw_done) done_c = c;
        saw_done = 1'b1;
      end
      if (saw_done) after++;
      if (after > 3) break;
      @(posedge clk); #1;
      if (accepted) txn_valid = 1'b0;
      if (hs) pi++;
      pix_valid = (kind == K_STREAM) && (pi < count) && !(pi == stall_idx && stall_left > 0);
      pix_data = (pi < src.size()) ? src[pi] : 16'h0;
    end
    txn_valid = 1'b0;
    pix_valid = 1'b0;
    lat = saw_done ? done_c - acc : -1;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel16 = s[0];
      #1;
      checks++;
      if ({m_cs_n, m_wr_n, m_dc, m_ready, m_busy, m_done, m_pix_ready} !== 7'b1111000 || m_d !== 16'h0) begin
        failures++;
        $display("FAIL reset_hold bus16=%0d got ctl=%b d=%h want ctl=1111000 d=0000", s,
                 {m_cs_n, m_wr_n, m_dc, m_ready, m_busy, m_done, m_pix_ready}, m_d);
      end
    end
    @(posedge clk); #1; rst = 1'b0;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel16 = s[0];
      #1;
      checks++;
      if ({m_cs_n, m_wr_n, m_dc, m_ready, m_busy, m_done, m_pix_ready} !== 7'b1111000 || m_d !== 16'h0) begin
        failures++;
        $display("FAIL reset_release bus16=%0d got ctl=%b d=%h want ctl=1111000 d=0000", s,
                 {m_cs_n, m_wr_n, m_dc, m_ready, m_busy, m_done, m_pix_ready}, m_d);
      end
    end
  endtask

  task automatic test_cmd;
    logic [31:0] exp_trace;
    src.delete();
    run_txn(1'b0, K_CMD, 16'h002C, 0, -1);
    model_beats(1'b0, K_CMD, 16'h002C, 0);
    checks++;
    if (obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
      failures++;
      $display("FAIL cmd_beat got n=%0d first=%h want n=1 first=%h", obs_q.size(),
               (obs_q.size() > 0) ? obs_q[0] : 17'h0, exp_q[0]);
    end
    checks++;
    if (lat != P + R + 1) begin
      failures++;
      $display("FAIL cmd_latency got %0d want %0d", lat, P + R + 1);
    end
    exp_trace = '1;
    for (int k = 1; k <= P; k++) exp_trace[k] = 1'b0;
    checks++;
    if (wr_trace[P + R + 1:0] !== exp_trace[P + R + 1:0]) begin
      failures++;
      $display("FAIL cmd_wr_waveform got %b want %b", wr_trace[P + R + 1:0], exp_trace[P + R + 1:0]);
    end
    checks++;
    if (n_done != 1) begin
      failures++;
      $display("FAIL cmd_done_count got %0d want 1", n_done);
    end
  endtask

  task automatic test_stream;
    src.delete();
    src.push_back(16'hF800);
    src.push_back(16'h07E0);
    run_txn(1'b0, K_STREAM, 16'h0, 2, -1);
    exp_q = '{17'h100F8, 17'h10000, 17'h10007, 17'h100E0};
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL stream_beat_count got %0d want %0d", obs_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL stream_beat[%0d] got %h want %h", i, obs_q[i], exp_q[i]);
        end
      end
    end
    checks++;
    if (n_hs != 2 || n_done != 1) begin
      failures++;
      $display("FAIL stream_handshakes got hs=%0d done=%0d want hs=2 done=1", n_hs, n_done);
    end
    checks++;
    if (lat != exp_latency(1'b0, K_STREAM, 2, 0)) begin
      failures++;
      $display("FAIL stream_latency got %0d want %0d", lat, exp_latency(1'b0, K_STREAM, 2, 0));
    end
  endtask

  task automatic test_fill16;
    src.delete();
    run_txn(1'b1, K_FILL, 16'h001F, 3, -1);
    checks++;
    if (obs_q.size() != 3 || obs_q[0] !== 17'h1001F || obs_q[1] !== 17'h1001F || obs_q[2] !== 17'h1001F) begin
      failures++;
      $display("FAIL fill16_beats got n=%0d first=%h want n=3 all=1001f", obs_q.size(),
               (obs_q.size() > 0) ? obs_q[0] : 17'h0);
    end
    checks++;
    if (pr_seen !== 1'b0) begin
      failures++;
      $display("FAIL fill16_pix_ready got asserted want never");
    end
    checks++;
    if (lat != 10) begin
      failures++;
      $display("FAIL fill16_latency got %0d want 10", lat);
    end
  endtask

  task automatic test_stall;
    src.delete();
    src.push_back(16'($urandom));
    src.push_back(16'($urandom));
    run_txn(1'b0, K_STREAM, 16'h0, 2, 1);
    model_beats(1'b0, K_STREAM, 16'h0, 2);
    checks++;
    if (stall_seen != 5 || stall_bad != 0) begin
      failures++;
      $display("FAIL stall_bus_idle got stall_cycles=%0d bad=%0d want 5 and 0", stall_seen, stall_bad);
    end
    checks++;
    if (obs_q != exp_q) begin
      failures++;
      $display("FAIL stall_byte_order got n=%0d want n=%0d (contents differ)", obs_q.size(), exp_q.size());
    end
    checks++;
    if (lat != exp_latency(1'b0, K_STREAM, 2, 5)) begin
      failures++;
      $display("FAIL stall_latency got %0d want %0d", lat, exp_latency(1'b0, K_STREAM, 2, 5));
    end
  endtask

  task automatic test_zero_count;
    src.delete();
    for (int k = K_STREAM; k <= K_FILL; k++) begin
      run_txn(1'b0, k, 16'h1234, 0, -1);
      checks++;
      if (obs_q.size() != 0 || n_done != 1 || lat != 1 || n_cs_low != 1) begin
        failures++;
        $display("FAIL zero_count kind=%0d got edges=%0d done=%0d lat=%0d cs_low=%0d want 0 1 1 1",
                 k, obs_q.size(), n_done, lat, n_cs_low);
      end
    end
  endtask

  task automatic test_random;
    for (int it = 0; it < 10; it++) begin
      logic        s16;
      int          kind, count;
      logic [15:0] data;
      s16   = 1'($urandom_range(0, 1));
      kind  = $urandom_range(0, 3);
      count = $urandom_range(0, 4);
      data  = 16'($urandom);
      src.delete();
      for (int i = 0; i < count; i++) src.push_back(16'($urandom));
      run_txn(s16, kind, data, count, -1);
      model_beats(s16, kind, data, count);
      checks++;
      if (obs_q != exp_q) begin
        failures++;
        $display("FAIL rand[%0d]_beats kind=%0d bus16=%0d count=%0d got n=%0d want n=%0d (contents differ)",
                 it, kind, s16, count, obs_q.size(), exp_q.size());
      end
      checks++;
      if (lat != exp_latency(s16, kind, count, 0) || n_done != 1) begin
        failures++;
        $display("FAIL rand[%0d]_timing kind=%0d got lat=%0d done=%0d want lat=%0d done=1",
                 it, kind, lat, n_done, exp_latency(s16, kind, count, 0));
      end
      checks++;
      if (n_hs != ((kind == K_STREAM) ? count : 0) || n_cs_low != lat) begin
        failures++;
        $display("FAIL rand[%0d]_hs_cs kind=%0d got hs=%0d cs_low=%0d want hs=%0d cs_low=%0d",
                 it, kind, n_hs, n_cs_low, (kind == K_STREAM) ? count : 0, lat);
      end
    end
  endtask

  task automatic test_reset_mid;
    int   edges, seen_done;
    logic prev, hit;
    edges = 0; seen_done = 0; prev = 1'b1; hit = 1'b0;
    @(posedge clk); #1;
    sel16 = 1'b0;
    txn_kind = 2'd3; txn_data = 16'hA5C3; txn_count = 17'd100; txn_valid = 1'b1;
    @(posedge clk); #1;
    txn_valid = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (m_done === 1'b1) seen_done++;
      if (prev === 1'b0 && m_wr_n === 1'b1) edges++;
      prev = m_wr_n;
      if (edges == 1 && m_wr_n === 1'b0) begin hit = 1'b1; break; end
    end
    checks++;
    if (!hit) begin
      failures++;
      $display("FAIL midrst_reach_beat2 got edges=%0d want second beat low within 40 cycles", edges);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({m_cs_n, m_wr_n, m_dc, m_ready, m_busy, m_done, m_pix_ready} !== 7'b1111000 || m_d !== 16'h0) begin
      failures++;
      $display("FAIL midrst_async got ctl=%b d=%h want ctl=1111000 d=0000",
               {m_cs_n, m_wr_n, m_dc, m_ready, m_busy, m_done, m_pix_ready}, m_d);
    end
    @(posedge clk); #1; rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (m_done === 1'b1) seen_done++;
    end
    checks++;
    if (seen_done != 0) begin
      failures++;
      $display("FAIL midrst_no_done got %0d done pulses want 0", seen_done);
    end
    src.delete();
    run_txn(1'b0, K_CMD, 16'h0029, 0, -1);
    checks++;
    if (obs_q.size() != 1 || obs_q[0] !== 17'h00029 || lat != P + R + 1 || n_done != 1) begin
      failures++;
      $display("FAIL midrst_next_cmd got n=%0d first=%h lat=%0d done=%0d want n=1 first=00029 lat=%0d done=1",
               obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 17'h0, lat, n_done, P + R + 1);
    end
  endtask

  initial begin
    test_reset();
    test_cmd();
    test_stream();
    test_fill16();
    test_stall();
    test_zero_count();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
